cell_paint_engine: RTL and testbench



---
 rtl/cell_paint_engine.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_cell_paint_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_paint_engine.sv
`default_nettype none
// ============================================================================
// cell_paint_engine
//   Expands cursor/paint/erase/clear commands on a cell grid into a
//   backpressured pixel stream.
//   Revision: 1.0
// ============================================================================
module cell_paint_engine #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int CELL_DIM      = 5,
    parameter int COLOUR_BITS   = 3,
    parameter int BRUSH         = 1,
    parameter logic [COLOUR_BITS-1:0] CURSOR_COLOUR = 3'b110,
    parameter logic [COLOUR_BITS-1:0] GRID_COLOUR   = 3'b000,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR     = 3'b111,
    localparam int COLS = SCREEN_WIDTH / CELL_DIM,
    localparam int ROWS = SCREEN_HEIGHT / CELL_DIM,
    localparam int PB   = $clog2((SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT),
    localparam int CB   = $clog2((COLS > ROWS) ? COLS : ROWS)
) (
    input  logic                   iClk,
    input  logic                   iReset,
    input  logic                   iCmdValid,
    output logic                   oCmdReady,
    input  logic [1:0]             iCmd,
    input  logic [CB-1:0]          iX_cell,
    input  logic [CB-1:0]          iY_cell,
    input  logic [COLOUR_BITS-1:0] iColour,
    output logic [PB-1:0]          oX_pixel,
    output logic [PB-1:0]          oY_pixel,
    output logic [COLOUR_BITS-1:0] oColour,
    output logic                   oPlot,
    input  logic                   iReady,
    output logic                   oDone,
    output logic                   oErr
);

    localparam int OB = $clog2(CELL_DIM);
    localparam logic [1:0] CMD_CURSOR = 2'd0;
    localparam logic [1:0] CMD_PAINT  = 2'd1;
    localparam logic [1:0] CMD_CLEAR  = 2'd3;

    localparam logic [OB-1:0] OFF_LAST  = OB'(CELL_DIM - 1);
    localparam logic [OB-1:0] OFF_ILAST = OB'(CELL_DIM - 2);
    localparam logic [PB-1:0] X_LAST    = PB'(SCREEN_WIDTH - 1);
    localparam logic [PB-1:0] Y_LAST    = PB'(SCREEN_HEIGHT - 1);
    localparam logic [CB:0]   COL_MAX   = (CB+1)'(COLS - 1);
    localparam logic [CB:0]   ROW_MAX   = (CB+1)'(ROWS - 1);
    localparam logic [CB-1:0] HALF      = CB'(BRUSH / 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CUR_ERASE = 3'd1,
        CUR_DRAW  = 3'd2,
        FILL      = 3'd3,
        CLEAR     = 3'd4,
        FINISH    = 3'd5
    } state_t;

    state_t state, next_state;

    logic [1:0]             cmd_q;
    logic [CB-1:0]          cell_x, cell_y;
    logic [COLOUR_BITS-1:0] colour_q;
    logic [CB-1:0]          prev_x, prev_y;
    logic                   cursor_valid;
    logic                   err_q;
    logic [OB-1:0]          off_x, off_y;
    logic [CB-1:0]          fill_x, fill_y;
    logic [CB-1:0]          x_lo, x_hi, y_hi;
    logic [PB-1:0]          px, py;
    logic [OB-1:0]          mx, my;

    logic                   scan_adv;
    logic                   out_of_range;
    logic [CB-1:0]          x_lo_w, x_hi_w, y_lo_w, y_hi_w;
    logic [CB:0]            x_sum, y_sum;
    logic [CB-1:0]          cur_x, cur_y;
    logic                   on_border;
    logic                   cur_last;
    logic                   fill_last;
    logic                   clear_grid;

    function automatic logic [PB-1:0] cell_pix(input logic [CB-1:0] c, input logic [OB-1:0] o);
        logic [PB:0] p;
        p = (PB+1)'(c) * (PB+1)'(CELL_DIM) + (PB+1)'(o);
        return p[PB-1:0];
    endfunction

    // Brush footprint clipped to the grid; no wrap at either edge.
    always_comb begin
        x_sum        = {1'b0, iX_cell} + {1'b0, HALF};
        y_sum        = {1'b0, iY_cell} + {1'b0, HALF};
        x_lo_w       = (iX_cell < HALF) ? '0 : iX_cell - HALF;
        y_lo_w       = (iY_cell < HALF) ? '0 : iY_cell - HALF;
        x_hi_w       = (x_sum > COL_MAX) ? COL_MAX[CB-1:0] : x_sum[CB-1:0];
        y_hi_w       = (y_sum > ROW_MAX) ? ROW_MAX[CB-1:0] : y_sum[CB-1:0];
        out_of_range = ({1'b0, iX_cell} > COL_MAX) || ({1'b0, iY_cell} > ROW_MAX);
    end

    always_comb begin
        cur_x      = (state == CUR_ERASE) ? prev_x : cell_x;
        cur_y      = (state == CUR_ERASE) ? prev_y : cell_y;
        on_border  = (off_x == '0) || (off_x == OFF_LAST) || (off_y == '0) || (off_y == OFF_LAST);
        cur_last   = (off_x == OFF_LAST) && (off_y == OFF_LAST);
        fill_last  = (off_x == OFF_ILAST) && (off_y == OFF_ILAST) &&
                     (fill_x == x_hi) && (fill_y == y_hi);
        clear_grid = (mx == '0) || (mx == OFF_LAST) || (my == '0) || (my == OFF_LAST);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        oCmdReady  = 1'b0;
        oPlot      = 1'b0;
        oDone      = 1'b0;
        oErr       = 1'b0;
        oX_pixel   = '0;
        oY_pixel   = '0;
        oColour    = BG_COLOUR;
        scan_adv   = 1'b0;
        case (state)
            IDLE: begin
                oCmdReady = 1'b1;
                if (iCmdValid) begin
                    if (iCmd == CMD_CLEAR) begin
                        next_state = CLEAR;
                    end else if (out_of_range) begin
                        next_state = FINISH;
                    end else if (iCmd == CMD_CURSOR) begin
                        next_state = (cursor_valid && ((iX_cell != prev_x) || (iY_cell != prev_y)))
                                     ? CUR_ERASE : CUR_DRAW;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            CUR_ERASE, CUR_DRAW: begin
                oX_pixel = cell_pix(cur_x, off_x);
                oY_pixel = cell_pix(cur_y, off_y);
                oPlot    = on_border;
                oColour  = (state == CUR_ERASE) ? GRID_COLOUR : CURSOR_COLOUR;
                scan_adv = !on_border || iReady;
                if (scan_adv && cur_last) begin
                    next_state = (state == CUR_ERASE) ? CUR_DRAW : FINISH;
                end
            end
            FILL: begin
                oX_pixel = cell_pix(fill_x, off_x);
                oY_pixel = cell_pix(fill_y, off_y);
                oPlot    = 1'b1;
                oColour  = (cmd_q == CMD_PAINT) ? colour_q : BG_COLOUR;
                scan_adv = iReady;
                if (iReady && fill_last) begin
                    next_state = FINISH;
                end
            end
            CLEAR: begin
                oX_pixel = px;
                oY_pixel = py;
                oPlot    = 1'b1;
                oColour  = clear_grid ? GRID_COLOUR : BG_COLOUR;
                scan_adv = iReady;
                if (iReady && (px == X_LAST) && (py == Y_LAST)) begin
                    next_state = FINISH;
                end
            end
            FINISH: begin
                oDone      = 1'b1;
                oErr       = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            cmd_q        <= '0;
            cell_x       <= '0;
            cell_y       <= '0;
            colour_q     <= '0;
            prev_x       <= '0;
            prev_y       <= '0;
            cursor_valid <= 1'b0;
            err_q        <= 1'b0;
            off_x        <= '0;
            off_y        <= '0;
            fill_x       <= '0;
            fill_y       <= '0;
            x_lo         <= '0;
            x_hi         <= '0;
            y_hi         <= '0;
            px           <= '0;
            py           <= '0;
            mx           <= '0;
            my           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iCmdValid) begin
                        cmd_q    <= iCmd;
                        cell_x   <= iX_cell;
                        cell_y   <= iY_cell;
                        colour_q <= iColour;
                        err_q    <= (iCmd != CMD_CLEAR) && out_of_range;
                        x_lo     <= x_lo_w;
                        x_hi     <= x_hi_w;
                        y_hi     <= y_hi_w;
                        fill_x   <= x_lo_w;
                        fill_y   <= y_lo_w;
                        px       <= '0;
                        py       <= '0;
                        mx       <= '0;
                        my       <= '0;
                        // Fill scans start at the first interior offset.
                        if (iCmd == CMD_CURSOR || iCmd == CMD_CLEAR) begin
                            off_x <= '0;
                            off_y <= '0;
                        end else begin
                            off_x <= OB'(1);
                            off_y <= OB'(1);
                        end
                    end
                end
                CUR_ERASE, CUR_DRAW: begin
                    if (scan_adv) begin
                        if (off_x == OFF_LAST) begin
                            off_x <= '0;
                            if (off_y == OFF_LAST) begin
                                off_y <= '0;
                                if (state == CUR_DRAW) begin
                                    prev_x       <= cell_x;
                                    prev_y       <= cell_y;
                                    cursor_valid <= 1'b1;
                                end
                            end else begin
                                off_y <= off_y + 1'b1;
                            end
                        end else begin
                            off_x <= off_x + 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (scan_adv) begin
                        if (off_x == OFF_ILAST) begin
                            off_x <= OB'(1);
                            if (off_y == OFF_ILAST) begin
                                off_y <= OB'(1);
                                if (fill_x == x_hi) begin
                                    fill_x <= x_lo;
                                    fill_y <= fill_y + 1'b1;
                                end else begin
                                    fill_x <= fill_x + 1'b1;
                                end
                            end else begin
                                off_y <= off_y + 1'b1;
                            end
                        end else begin
                            off_x <= off_x + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // mx/my track pixel position modulo CELL_DIM alongside px/py.
                    if (scan_adv) begin
                        if (px == X_LAST) begin
                            px <= '0;
                            mx <= '0;
                            if (py == Y_LAST) begin
                                py           <= '0;
                                my           <= '0;
                                cursor_valid <= 1'b0;
                            end else begin
                                py <= py + 1'b1;
                                my <= (my == OFF_LAST) ? '0 : my + 1'b1;
                            end
                        end else begin
                            px <= px + 1'b1;
                            mx <= (mx == OFF_LAST) ? '0 : mx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_paint_engine.sv
`default_nettype none
// ============================================================================
// tb_cell_paint_engine
//   Directed scoreboard bench for cell_paint_engine on a reduced screen.
//   Revision: 1.0
// ============================================================================
module tb_cell_paint_engine;

    localparam int W     = 45;
    localparam int H     = 35;
    localparam int D     = 5;
    localparam int CBITS = 3;
    localparam int BR    = 3;
    localparam int COLS  = W / D;
    localparam int ROWS  = H / D;
    localparam int PB    = $clog2((W > H) ? W : H);
    localparam int CB    = $clog2((COLS > ROWS) ? COLS : ROWS);
    localparam logic [CBITS-1:0] CUR_C  = 3'b110;
    localparam logic [CBITS-1:0] GRID_C = 3'b000;
    localparam logic [CBITS-1:0] BG_C   = 3'b111;

    typedef struct packed {
        logic [PB-1:0]    x;
        logic [PB-1:0]    y;
        logic [CBITS-1:0] c;
    } pix_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd;
    logic [CB-1:0]    x_cell, y_cell;
    logic [CBITS-1:0] colour_in;
    logic [PB-1:0]    x_pix, y_pix;
    logic [CBITS-1:0] colour_out;
    logic             plot;
    logic             ready;
    logic             done;
    logic             err;

    cell_paint_engine #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .CELL_DIM     (D),
        .COLOUR_BITS  (CBITS),
        .BRUSH        (BR),
        .CURSOR_COLOUR(CUR_C),
        .GRID_COLOUR  (GRID_C),
        .BG_COLOUR    (BG_C)
    ) dut (
        .iClk     (clk),
        .iReset   (rst),
        .iCmdValid(cmd_valid),
        .oCmdReady(cmd_ready),
        .iCmd     (cmd),
        .iX_cell  (x_cell),
        .iY_cell  (y_cell),
        .iColour  (colour_in),
        .oX_pixel (x_pix),
        .oY_pixel (y_pix),
        .oColour  (colour_out),
        .oPlot    (plot),
        .iReady   (ready),
        .oDone    (done),
        .oErr     (err)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    pix_t sb[$];
    logic chk_en = 1'b1;
    logic exp_err = 1'b0;
    logic done_seen = 1'b0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   last_pop = -10;
    int   m_prev_x = 0, m_prev_y = 0;
    logic m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void push_pix(input int x, input int y, input logic [CBITS-1:0] c);
        pix_t p;
        p.x = x[PB-1:0];
        p.y = y[PB-1:0];
        p.c = c;
        sb.push_back(p);
    endfunction

    function automatic void push_outline(input int cx, input int cy, input logic [CBITS-1:0] c);
        for (int oy = 0; oy < D; oy++)
            for (int ox = 0; ox < D; ox++)
                if (ox == 0 || ox == D-1 || oy == 0 || oy == D-1)
                    push_pix(cx*D + ox, cy*D + oy, c);
    endfunction

    function automatic void model_cursor(input int cx, input int cy);
        if (m_valid && (cx != m_prev_x || cy != m_prev_y))
            push_outline(m_prev_x, m_prev_y, GRID_C);
        push_outline(cx, cy, CUR_C);
        m_prev_x = cx;
        m_prev_y = cy;
        m_valid  = 1'b1;
    endfunction

    function automatic void model_fill(input int cx, input int cy, input logic [CBITS-1:0] c);
        for (int ry = cy - BR/2; ry <= cy + BR/2; ry++)
            for (int rx = cx - BR/2; rx <= cx + BR/2; rx++)
                if (rx >= 0 && rx < COLS && ry >= 0 && ry < ROWS)
                    for (int oy = 1; oy < D-1; oy++)
                        for (int ox = 1; ox < D-1; ox++)
                            push_pix(rx*D + ox, ry*D + oy, c);
    endfunction

    function automatic void model_clear();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                push_pix(x, y, ((x % D) == 0 || (x % D) == D-1 || (y % D) == 0 || (y % D) == D-1)
                               ? GRID_C : BG_C);
        m_valid = 1'b0;
    endfunction

    function automatic logic ready_pat(input int mode, input int n);
        case (mode)
            1:       return ($urandom_range(0, 3) != 0);
            2:       return !(n >= 3 && n <= 6);
            default: return 1'b1;
        endcase
    endfunction

    // Scoreboard: every presented pixel must match the head; it is consumed on handshake.
    always @(negedge clk) begin
        cyc++;
        if (done) done_cnt++;
        if (chk_en && !rst) begin
            if (plot) begin
                if (sb.size() == 0) begin
                    check("extra_pixel", {x_pix, y_pix, colour_out}, 0);
                end else begin
                    check("pixel", 32'({x_pix, y_pix, colour_out}), 32'(sb[0]));
                    if (ready) begin
                        void'(sb.pop_front());
                        last_pop = cyc;
                    end
                end
            end
            if (!done) check("err_without_done", err, 0);
            if (done) begin
                done_seen = 1'b1;
                check("done_no_plot", plot, 0);
                check("err_flag", err, exp_err);
                check("sb_empty_at_done", sb.size(), 0);
                if (!exp_err) check("done_latency", cyc - last_pop, 1);
            end
        end
    end

    task automatic run_cmd(input logic [1:0] c, input int x, input int y,
                           input logic [CBITS-1:0] col, input int mode, input logic e);
        int n;
        exp_err   = e;
        done_seen = 1'b0;
        last_pop  = -10;
        cmd       = c;
        x_cell    = x[CB-1:0];
        y_cell    = y[CB-1:0];
        colour_in = col;
        cmd_valid = 1'b1;
        ready     = 1'b1;
        check("ready_in_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("ready_low_busy", cmd_ready, 0);
        n = 1;
        ready = ready_pat(mode, n);
        while (!done_seen && n < 5000) begin
            @(posedge clk); #1;
            n++;
            ready = ready_pat(mode, n);
        end
        if (!done_seen) begin
            check("timeout", 0, 1);
            sb.delete();
        end else begin
            check("done_one_cycle", done, 0);
            check("ready_after_done", cmd_ready, 1);
        end
        ready = 1'b1;
    endtask

    initial begin
        int d0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = '0;
        x_cell    = '0;
        y_cell    = '0;
        colour_in = '0;
        ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot", plot, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_x", x_pix, 0);
        check("rst_y", y_pix, 0);
        check("rst_colour", colour_out, BG_C);
        check("rst_cmd_ready", cmd_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        model_cursor(2, 3);         run_cmd(2'd0, 2, 3, 3'b000, 0, 1'b0);
        model_cursor(3, 3);         run_cmd(2'd0, 3, 3, 3'b000, 1, 1'b0);
        model_cursor(3, 3);         run_cmd(2'd0, 3, 3, 3'b000, 0, 1'b0);
        model_fill(0, 0, 3'b010);   run_cmd(2'd1, 0, 0, 3'b010, 2, 1'b0);
        model_fill(8, 6, 3'b101);   run_cmd(2'd1, 8, 6, 3'b101, 1, 1'b0);
        model_fill(8, 6, BG_C);     run_cmd(2'd2, 8, 6, 3'b101, 0, 1'b0);
        model_fill(4, 3, 3'b011);   run_cmd(2'd1, 4, 3, 3'b011, 1, 1'b0);

        run_cmd(2'd1, 9, 0, 3'b001, 0, 1'b1);
        run_cmd(2'd0, 0, 7, 3'b000, 0, 1'b1);
        run_cmd(2'd2, 15, 15, 3'b000, 0, 1'b1);
        model_cursor(2, 2);         run_cmd(2'd0, 2, 2, 3'b000, 1, 1'b0);

        model_clear();              run_cmd(2'd3, 0, 0, 3'b000, 0, 1'b0);
        model_cursor(4, 4);         run_cmd(2'd0, 4, 4, 3'b000, 0, 1'b0);

        // Abort a clear part-way through with reset.
        chk_en    = 1'b0;
        cmd       = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (W*10 + 3) @(posedge clk);
        #1;
        check("mid_clear_plot", plot, 1);
        d0  = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_plot", plot, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_done", done, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, d0);
        sb.delete();
        chk_en   = 1'b1;
        m_valid  = 1'b0;
        m_prev_x = 0;
        m_prev_y = 0;
        model_cursor(1, 1);         run_cmd(2'd0, 1, 1, 3'b000, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
